dense_layer_param_bn_act: RTL
=============================

DENSE_LAYER_PARAM_BN_ACT -- requirements
Module: dense_layer_param_bn_act

Interface
REQ-001 Parameter IN_DIM, 2048, input vector length; multiple of CHUNK_SIZE.
REQ-002 Parameter OUT_DIM, 128, number of output neurons.
REQ-003 Parameter CHUNK_SIZE, 256, MAC chunk length; sets in_idx/chunk_idx split of weight address.
REQ-004 Parameter DATA_W, 8, signed width of inputs, weights, bias, scale, shift.
REQ-005 Parameter ACC_W, 32, signed accumulator width.
REQ-006 Parameter ACC_SHIFT, 5, arithmetic right shift applied to accumulator before BN.
REQ-007 Parameter BN_SHIFT, 7, arithmetic right shift applied after scale/shift.
REQ-008 clk  in  1  single clock; all state changes on rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 start  in  1  one-cycle request to begin load+compute; sampled only in IDLE.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 done  out  1  one-cycle pulse when all outputs written.
REQ-013 in_valid / in_ready  in / out  1 / 1  input stream handshake.
REQ-014 in_data  in  DATA_W  signed input element, index order 0..IN_DIM-1.
REQ-015 w_addr / w_data  out / in  clog2(IN_DIM*OUT_DIM) / DATA_W  weight memory; w_addr = out_idx*IN_DIM + chunk_idx*CHUNK_SIZE + in_idx; data valid one cycle after address.
REQ-016 p_addr  out  clog2(OUT_DIM)  neuron parameter address (= out_idx).
REQ-017 bias_data / scale_data / shift_data  in  DATA_W each  signed, combinational from p_addr.
REQ-018 read_addr / read_data  in / out  clog2(OUT_DIM) / OUT_W  combinational read of output buffer.

Function
REQ-019 States IDLE, LOAD, MAC, POST, DONE; IDLE->LOAD on start; LOAD->MAC after IN_DIM accepted words; MAC->POST after last product accumulated; POST->MAC (next neuron) or DONE (last neuron); DONE->IDLE after one cycle.
REQ-020 in_ready high only in LOAD; a word is accepted when in_valid && in_ready; stalls in in_valid are tolerated indefinitely.
REQ-021 MAC is pipelined: address issued at cycle k, product accumulated at k+1; IN_DIM+1 cycles per neuron in MAC, 1 cycle in POST.
REQ-022 Accumulator initialised to sign-extended bias_data at start of each neuron; every product added with saturation to ACC_W signed bounds (no wrap).
REQ-023 POST: a = clamp(acc >>> ACC_SHIFT, -128, 127); bn = clamp((a*scale_data + shift_data) >>> BN_SHIFT, -128, 127); result written to out_buf[out_idx].
REQ-024 Total latency start->done = 1 + IN_DIM (no stalls) + OUT_DIM*(IN_DIM+2) + 1 cycles.
REQ-025 start while busy ignored; no restart, no state change.
REQ-026 out_buf entries not yet rewritten in a run retain prior-run values; read_data is valid at all times.
REQ-027 done asserts only in DONE state, exactly one cycle per run.

Reset
REQ-028 reset forces IDLE, busy=0, done=0, in_ready=0, acc=0, all indices 0, all out_buf entries 0, immediately and regardless of state (including mid-LOAD/MAC).
REQ-029 After reset deassertion block waits for a new start; no partial run resumes.

Configuration
REQ-030 Macro DENSE_LAYER_RELU6_EN defined: OUT_W=4, out_buf stores relu6 = min((bn+128)/42, 6), unsigned.
REQ-031 Macro undefined: OUT_W=8, out_buf stores bn unchanged (signed int8, no activation); all other behaviour identical.

Verification (IN_DIM=4, OUT_DIM=2, CHUNK_SIZE=2, other defaults, DENSE_LAYER_RELU6_EN defined unless stated)
REQ-032 Inputs all 1, weights all 32, bias 0, scale 64, shift 0 -> out_buf[0]=out_buf[1]=3; done one pulse at cycle 1+4+2*6+1=18 after start.
REQ-033 Inputs all 127, weights all 127, bias 0, scale 127, shift 0 -> a clamps to 127, bn=126, output 6; macro undefined -> output 126.
REQ-034 Inputs all 127, weights all -128, scale 127, shift 0 -> a=-128, bn=-127, output 0; macro undefined -> output -127 (0x81).
REQ-035 in_valid toggled 1/0 every cycle during LOAD -> identical outputs to REQ-032, latency grows by exactly 4 cycles; start pulsed during MAC -> ignored, single done.
REQ-036 reset asserted during MAC of neuron 1 -> same cycle busy=0, done=0, read_data=0 for all addresses; subsequent start completes REQ-032 results normally.

Source files
------------

// File: rtl/dense_layer_param_bn_act.sv
// rtl/dense_layer_param_bn_act.sv - dense layer with per-neuron batch-norm; ReLU6 output when DENSE_LAYER_RELU6_EN is defined
module dense_layer_param_bn_act #(
    parameter int IN_DIM     = 2048,
    parameter int OUT_DIM    = 128,
    parameter int CHUNK_SIZE = 256,
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 32,
    parameter int ACC_SHIFT  = 5,
    parameter int BN_SHIFT   = 7,
    localparam int AW = $clog2(IN_DIM * OUT_DIM),
    localparam int PW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1,
`ifdef DENSE_LAYER_RELU6_EN
    localparam int OUT_W = 4
`else
    localparam int OUT_W = 8
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic [AW-1:0]            w_addr,
    input  logic signed [DATA_W-1:0] w_data,
    output logic [PW-1:0]            p_addr,
    input  logic signed [DATA_W-1:0] bias_data,
    input  logic signed [DATA_W-1:0] scale_data,
    input  logic signed [DATA_W-1:0] shift_data,
    input  logic [PW-1:0]            read_addr,
    output logic [OUT_W-1:0]         read_data
);
    localparam int NCH = IN_DIM / CHUNK_SIZE;
    localparam int CW  = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int IW  = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
    localparam int PRW = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] A_MAX   = ACC_W'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W-1:0] A_MIN   = ACC_W'(-(2**(DATA_W-1)));
    localparam logic signed [PRW:0]     B_MAX   = (PRW+1)'(2**(DATA_W-1) - 1);
    localparam logic signed [PRW:0]     B_MIN   = (PRW+1)'(-(2**(DATA_W-1)));

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_POST, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            in_idx_q, in_idx_d;
    logic [KW-1:0]            chunk_idx_q, chunk_idx_d;
    logic [PW-1:0]            out_idx_q, out_idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] x_q, x_d;
    logic                     prod_vld_q, prod_vld_d;
    logic                     last_q, last_d;
    logic                     issued_q, issued_d;
    logic signed [DATA_W-1:0] in_buf_q [IN_DIM];
    logic signed [DATA_W-1:0] in_buf_d [IN_DIM];
    logic [OUT_W-1:0]         out_buf_q [OUT_DIM];
    logic [OUT_W-1:0]         out_buf_d [OUT_DIM];

    logic [IW-1:0]            flat_idx;
    logic                     idx_last;
    logic                     advance;
    logic signed [PRW-1:0]    prod;
    logic signed [ACC_W:0]    sum_wide;
    logic signed [ACC_W-1:0]  acc_sat;
    logic signed [ACC_W-1:0]  acc_shr;
    logic signed [DATA_W-1:0] a_val;
    logic signed [PRW:0]      bn_raw;
    logic signed [PRW:0]      bn_shr;
    logic signed [DATA_W-1:0] bn_val;
    logic [OUT_W-1:0]         act_val;

    // Address generation, saturating MAC datapath and post-processing arithmetic
    always_comb begin
        flat_idx  = IW'(int'(chunk_idx_q) * CHUNK_SIZE + int'(in_idx_q));
        idx_last  = (in_idx_q == CW'(CHUNK_SIZE - 1)) && (chunk_idx_q == KW'(NCH - 1));
        w_addr    = AW'(int'(out_idx_q) * IN_DIM + int'(flat_idx));
        p_addr    = out_idx_q;
        read_data = out_buf_q[read_addr];
        prod      = x_q * w_data;
        sum_wide  = (ACC_W+1)'(acc_q) + (ACC_W+1)'(prod);
        // Overflow shows up as the two top bits of the widened sum disagreeing
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1])
            acc_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        else
            acc_sat = sum_wide[ACC_W-1:0];
        acc_shr = acc_q >>> ACC_SHIFT;
        if (acc_shr > A_MAX)      a_val = A_MAX[DATA_W-1:0];
        else if (acc_shr < A_MIN) a_val = A_MIN[DATA_W-1:0];
        else                      a_val = acc_shr[DATA_W-1:0];
        bn_raw = (PRW+1)'(a_val) * (PRW+1)'(scale_data) + (PRW+1)'(shift_data);
        bn_shr = bn_raw >>> BN_SHIFT;
        if (bn_shr > B_MAX)       bn_val = B_MAX[DATA_W-1:0];
        else if (bn_shr < B_MIN)  bn_val = B_MIN[DATA_W-1:0];
        else                      bn_val = bn_shr[DATA_W-1:0];
    end

`ifdef DENSE_LAYER_RELU6_EN
    logic [DATA_W-1:0] bn_off;
    logic [DATA_W-1:0] bn_q6;
    // ReLU6 quantisation: offset bn into unsigned range (flip MSB), divide by 42, cap at 6
    always_comb begin
        bn_off  = {~bn_val[DATA_W-1], bn_val[DATA_W-2:0]};
        bn_q6   = bn_off / DATA_W'(42);
        act_val = (bn_q6 > DATA_W'(6)) ? OUT_W'(6) : bn_q6[OUT_W-1:0];
    end
`else
    assign act_val = bn_val;
`endif

    // Next-state, index sequencing and buffer updates
    always_comb begin
        state_d     = state_q;
        in_idx_d    = in_idx_q;
        chunk_idx_d = chunk_idx_q;
        out_idx_d   = out_idx_q;
        acc_d       = acc_q;
        x_d         = x_q;
        prod_vld_d  = prod_vld_q;
        last_d      = last_q;
        issued_d    = issued_q;
        in_buf_d    = in_buf_q;
        out_buf_d   = out_buf_q;
        advance     = 1'b0;
        busy        = (state_q != S_IDLE);
        in_ready    = (state_q == S_LOAD);
        done        = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (in_valid) begin
                    in_buf_d[flat_idx] = in_data;
                    advance = 1'b1;
                    if (idx_last) state_d = S_MAC;
                end
            end
            S_MAC: begin
                // Issue side: one weight address per cycle until the vector is covered
                if (!issued_q) begin
                    x_d        = in_buf_q[flat_idx];
                    prod_vld_d = 1'b1;
                    last_d     = idx_last;
                    advance    = 1'b1;
                    if (idx_last) issued_d = 1'b1;
                end else begin
                    prod_vld_d = 1'b0;
                    last_d     = 1'b0;
                end
                // Accumulate side: first cycle of a neuron loads the bias
                if (!prod_vld_q) acc_d = ACC_W'(bias_data);
                else             acc_d = acc_sat;
                if (prod_vld_q && last_q) begin
                    issued_d = 1'b0;
                    state_d  = S_POST;
                end
            end
            S_POST: begin
                out_buf_d[out_idx_q] = act_val;
                if (out_idx_q == PW'(OUT_DIM - 1)) begin
                    out_idx_d = '0;
                    state_d   = S_DONE;
                end else begin
                    out_idx_d = out_idx_q + 1'b1;
                    state_d   = S_MAC;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (advance) begin
            if (idx_last) begin
                in_idx_d    = '0;
                chunk_idx_d = '0;
            end else if (in_idx_q == CW'(CHUNK_SIZE - 1)) begin
                in_idx_d    = '0;
                chunk_idx_d = chunk_idx_q + 1'b1;
            end else begin
                in_idx_d    = in_idx_q + 1'b1;
            end
        end
    end

    // Control and output-buffer registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_idx_q    <= '0;
            chunk_idx_q <= '0;
            out_idx_q   <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            prod_vld_q  <= 1'b0;
            last_q      <= 1'b0;
            issued_q    <= 1'b0;
            for (int i = 0; i < OUT_DIM; i++) out_buf_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            in_idx_q    <= in_idx_d;
            chunk_idx_q <= chunk_idx_d;
            out_idx_q   <= out_idx_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            prod_vld_q  <= prod_vld_d;
            last_q      <= last_d;
            issued_q    <= issued_d;
            out_buf_q   <= out_buf_d;
        end
    end

    // Input vector store; contents are only meaningful after a complete LOAD
    always_ff @(posedge clk) begin
        in_buf_q <= in_buf_d;
    end
endmodule
